md_engine: RTL
==============

MD_ENGINE -- requirements
Module: md_engine

Interface
REQ-001 Parameter MULT_CYCLES, default 5: Busy duration in cycles for mult, multu, madd.
REQ-002 Parameter DIV_CYCLES, default 10: Busy duration in cycles for div and divu.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 D1  in  32  operand A (rs): dividend or multiplicand; source for mthi/mtlo.
REQ-006 D2  in  32  operand B (rt): divisor or multiplier.
REQ-007 Op  in  2  00 mult, 01 multu, 10 div, 11 divu.
REQ-008 Start  in  1  single-cycle request; operands sampled on the same edge.
REQ-009 madd  in  1  qualifies Start with Op=00: accumulate the signed product into {HI,LO}.
REQ-010 WriteEnabled  in  1  direct write of D1 into HI or LO (mthi/mtlo).
REQ-011 HiLo  in  1  selects the target of the direct write: 1 HI, 0 LO.
REQ-012 Busy  out  1  operation in flight; the pipeline stalls on it.
REQ-013 HI  out  32  registered HI.
REQ-014 LO  out  32  registered LO.

Function
REQ-015 The FSM SHALL have two states, IDLE and RUN, with a down-counter cnt wide enough to hold max(MULT_CYCLES, DIV_CYCLES).
REQ-016 In IDLE, Start=1 SHALL latch D1, D2, Op and madd, load cnt with N (N = MULT_CYCLES or DIV_CYCLES per Op), and enter RUN.
REQ-017 Busy SHALL equal (state==RUN); it is high for exactly N cycles, beginning in the cycle after the Start edge.
REQ-018 In RUN, cnt SHALL decrement each cycle; on the edge where cnt==1 the result SHALL be written to HI/LO, state SHALL return to IDLE, and Busy SHALL fall on that same edge.
REQ-019 HI/LO SHALL hold their prior values for the whole of RUN; there is no partial-result visibility.
REQ-020 mult: {HI,LO} SHALL receive the 64-bit signed product; multu: the 64-bit unsigned product.
REQ-021 madd (Op=00, madd=1): {HI,LO} SHALL receive {HI,LO} + signed product, evaluated at completion, mod 2^64.
REQ-022 madd=1 with Op other than 00 SHALL be ignored; the operation runs as plain Op.
REQ-023 div: LO SHALL receive the signed quotient truncated toward zero, and HI SHALL receive the remainder carrying the dividend's sign.
REQ-024 divu: LO SHALL receive the unsigned quotient and HI the unsigned remainder.
REQ-025 div with D1=0x80000000 and D2=0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-026 A divide with D2=0 SHALL still hold Busy for DIV_CYCLES, and HI/LO SHALL remain unchanged.
REQ-027 Start while in RUN SHALL be ignored; it neither restarts the operation nor queues.
REQ-028 WriteEnabled while in RUN SHALL be ignored.
REQ-029 WriteEnabled in IDLE with Start=0 SHALL write D1 into HI (HiLo=1) or LO (HiLo=0) on that edge; Busy stays 0.
REQ-030 If Start and WriteEnabled are both 1 in IDLE, Start SHALL win and the direct write SHALL be dropped.
REQ-031 Start may be reasserted on the edge where Busy falls+1 (back-to-back); that operation sees the just-written HI/LO for madd.

Reset
REQ-032 reset=0 SHALL immediately, without waiting for clk, force state=IDLE, cnt=0, Busy=0, HI=0, LO=0, and clear the latched operands.
REQ-033 Reset asserted during RUN SHALL abort the operation with no HI/LO update, and Busy SHALL be 0 after release.
REQ-034 After reset is released, the block SHALL accept Start on the first rising edge.

Verification
REQ-035 mult with D1=0xFFFFFFFE (-2), D2=3 -> Busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA, and Busy=0 on that same edge.
REQ-036 multu with D1=D2=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-037 div with D1=-7 (0xFFFFFFF9), D2=2 -> Busy high for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu with D2=0 -> Busy high for 10 cycles, HI/LO unchanged.
REQ-038 mtlo with D1=5, then madd with D1=2, D2=3 (HI=0) -> LO=11, HI=0. A Start issued mid-RUN does not lengthen Busy.
REQ-039 Start div, then pull reset low at cycle 4 -> Busy, HI and LO are all 0 immediately. After release, mthi with D1=0x1234 -> HI=0x1234 next edge.
REQ-040 Start and WriteEnabled (HiLo=0, D1=9) asserted together with Op=01, D2=1 -> after 5 cycles LO=9 from the multiply, HI=0; the direct write is not applied.

Source files
------------

// File: rtl/md_engine.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// A single operation runs for a fixed latency; results land in HI/LO on the final edge only.
module md_engine #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  input  logic [1:0]  Op,
  input  logic        Start,
  input  logic        madd,
  input  logic        WriteEnabled,
  input  logic        HiLo,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAX_N + 1);

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [1:0]         op_q, op_d;
  logic               madd_q, madd_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  // Datapath results, all derived from the latched operands.
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [63:0]        acc;
  logic               div_zero;
  logic               div_ovf;
  logic [31:0]        b_safe;
  logic signed [31:0] sq, sr;
  logic [31:0]        q_s, r_s;
  logic [31:0]        q_u, r_u;

  always_comb begin
    prod_s   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u   = {32'd0, a_q} * {32'd0, b_q};
    acc      = {hi_q, lo_q} + prod_s;
    div_zero = (b_q == 32'd0);
    div_ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    // A zero divisor never commits a result; substitute 1 so the divider stays X-free.
    b_safe   = div_zero ? 32'd1 : b_q;
    sq       = $signed(a_q) / $signed(b_safe);
    sr       = $signed(a_q) % $signed(b_safe);
    q_s      = div_ovf ? 32'h8000_0000 : sq;
    r_s      = div_ovf ? 32'd0 : sr;
    q_u      = a_q / b_safe;
    r_u      = a_q % b_safe;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    madd_d  = madd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          a_d     = D1;
          b_d     = D2;
          op_d    = Op;
          madd_d  = madd;
          cnt_d   = Op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          state_d = RUN;
        end else if (WriteEnabled) begin
          if (HiLo) hi_d = D1;
          else      lo_d = D1;
        end
      end

      RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          unique case (op_q)
            OP_MULT: begin
              if (madd_q) {hi_d, lo_d} = acc;
              else        {hi_d, lo_d} = prod_s;
            end
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV: begin
              if (!div_zero) begin
                lo_d = q_s;
                hi_d = r_s;
              end
            end
            OP_DIVU: begin
              if (!div_zero) begin
                lo_d = q_u;
                hi_d = r_u;
              end
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  // NOTE: every register here, operands included, is cleared by reset; nothing relies on power-up values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      madd_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      madd_q  <= madd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy = (state_q == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
